// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: lane geometry, writeback FSM states and the
// round / ReLU / saturate requantizer used by the output stages.
package cnn_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned EXT_W  = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;

    localparam logic signed [EXT_W-1:0] QMAX = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] QMIN = ~QMAX;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OUT_W-1:0] requant(
        input logic [DATA_W-1:0] i_x,
        input logic              i_relu,
        input int unsigned       i_shift
    );
        logic signed [EXT_W-1:0] w_ext;
        logic signed [EXT_W-1:0] w_rnd;
        logic signed [EXT_W-1:0] w_q;
        w_ext = $signed({i_x[DATA_W-1], i_x});
        w_rnd = $signed(EXT_W'(1) << (i_shift - 1));
        w_q   = (w_ext + w_rnd) >>> i_shift;
        if (i_relu && w_q[EXT_W-1]) begin
            w_q = '0;
        end
        if (w_q > QMAX) begin
            w_q = QMAX;
        end else if (w_q < QMIN) begin
            w_q = QMIN;
        end
        return w_q[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous packed-word FIFO with occupancy count; depth must be a power of two.
module wb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // Storage is cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fmap_writeback.sv
// Output feature-map writeback: requantizes convolution sums to int8, buffers
// packed words and writes them row-major with frame-wrapping address counters.
module fmap_writeback
    import cnn_pkg::*;
#(
    parameter int unsigned LANES      = cnn_pkg::LANES,
    parameter int unsigned DATA_W     = cnn_pkg::DATA_W,
    parameter int unsigned OUT_W      = cnn_pkg::OUT_W,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 640,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      relu_en,
    input  logic                      mem_stall,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANES*OUT_W-1:0]    mem_wdata,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned COL_W = $clog2(COLS + 1);
    localparam int unsigned ROW_W = $clog2(ROWS + 1);

    wb_state_t              r_state;
    logic                   r_s1_valid;
    logic [LANES*OUT_W-1:0] r_s1_data;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic [ADDR_W-1:0]      r_addr;

    logic [LANES*OUT_W-1:0] w_q;
    logic [CNT_W-1:0]       w_count;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_last;

    // Lane k of the input maps to byte k of the output, so res1 lands in the top byte.
    always_comb begin
        w_q = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_q[i*OUT_W +: OUT_W] = requant(in_data[i*DATA_W +: DATA_W], relu_en, SHIFT);
        end
    end

    assign in_ready   = ((w_count + CNT_W'(r_s1_valid)) < CNT_W'(FIFO_DEPTH)) && (r_state != DONE);
    assign w_accept   = in_valid && in_ready;
    assign mem_we     = !w_empty && !mem_stall && (r_state == RUN);
    assign w_last     = (r_col == COL_W'(COLS - 1)) && (r_row == ROW_W'(ROWS - 1));
    assign mem_addr   = r_addr;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);

    wb_fifo #(
        .WIDTH (LANES * OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_data),
        .i_pop   (mem_we),
        .o_data  (mem_wdata),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // mem_addr tracks row*COLS+col incrementally, avoiding a multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_q;
            end
            case (r_state)
                // Next-frame beats taken before DONE still sit in S1/FIFO on return to IDLE.
                IDLE: begin
                    if (w_accept || r_s1_valid || !w_empty) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (mem_we) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_addr  <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_col == COL_W'(COLS - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_writeback.sv
// Scoreboard bench for fmap_writeback: a full-size instance and a 2x3 frame instance.
module tb_fmap_writeback;

    localparam int A_COLS = 80;
    localparam int A_ROWS = 640;
    localparam int B_COLS = 3;
    localparam int B_ROWS = 2;
    localparam int SH     = 8;

    typedef struct packed {
        logic [25:0] addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_valid, a_ready, a_relu, a_stall, a_we, a_busy, a_done;
    logic [127:0] a_data;
    logic [25:0]  a_addr;
    logic [63:0]  a_wdata;
    logic         b_valid, b_ready, b_relu, b_stall, b_we, b_busy, b_done;
    logic [127:0] b_data;
    logic [25:0]  b_addr;
    logic [63:0]  b_wdata;

    fmap_writeback #(
        .LANES(8), .DATA_W(16), .OUT_W(8), .SHIFT(SH),
        .COLS(A_COLS), .ROWS(A_ROWS), .FIFO_DEPTH(4), .ADDR_W(26)
    ) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .relu_en(a_relu), .mem_stall(a_stall),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .busy(a_busy), .frame_done(a_done)
    );

    fmap_writeback #(
        .COLS(B_COLS), .ROWS(B_ROWS)
    ) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .relu_en(b_relu), .mem_stall(b_stall),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .busy(b_busy), .frame_done(b_done)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   idx_a = 0, idx_b = 0;
    int   a_writes = 0, a_first_cyc = 0, a_last_cyc = 0;
    int   b_done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor((x + 2^(SH-1)) / 2^SH), optional ReLU, clamp to int8.
    function automatic logic [63:0] model_pack(input logic [127:0] d, input logic relu);
        logic [63:0] r;
        logic [15:0] lane;
        int v, q;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            lane = d[16*i +: 16];
            v = int'($signed(lane));
            q = (v + (1 << (SH - 1))) >>> SH;
            if (relu && q < 0) q = 0;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            r[8*i +: 8] = q[7:0];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            if (a_valid && a_ready) begin
                qa.push_back('{addr: 26'(idx_a % (A_COLS * A_ROWS)), data: model_pack(a_data, a_relu)});
                idx_a++;
            end
            if (b_valid && b_ready) begin
                qb.push_back('{addr: 26'(idx_b % (B_COLS * B_ROWS)), data: model_pack(b_data, b_relu)});
                idx_b++;
            end
        end
    end

    always @(negedge rst) begin
        qa.delete();
        qb.delete();
        idx_a = 0;
        idx_b = 0;
        a_writes = 0;
        b_done_cnt = 0;
    end

    always @(negedge clk) begin
        if (rst && a_we) begin
            a_writes++;
            a_last_cyc = cyc;
            if (a_writes == 1) a_first_cyc = cyc;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_write: addr=%0d data=0x%0h, no word expected", a_addr, a_wdata);
            end else begin
                ea = qa.pop_front();
                check("a_addr", 64'(a_addr), 64'(ea.addr));
                check("a_wdata", a_wdata, ea.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_done) b_done_cnt++;
        if (rst && b_we) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_write: addr=%0d data=0x%0h, no word expected", b_addr, b_wdata);
            end else begin
                eb = qb.pop_front();
                check("b_addr", 64'(b_addr), 64'(eb.addr));
                check("b_wdata", b_wdata, eb.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic send_a(input logic [127:0] d, input logic relu);
        logic acc;
        a_data = d;
        a_relu = relu;
        a_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = a_ready;
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: in_ready low for 100 cycles, expected acceptance");
        end
    endtask

    task automatic send_b(input logic [127:0] d, input logic relu);
        logic acc;
        b_data = d;
        b_relu = relu;
        b_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = b_ready;
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL b_accept_timeout: in_ready low for 100 cycles, expected acceptance");
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 200 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
        check({name, "_a_pending"}, 64'(qa.size()), 64'd0);
        check({name, "_b_pending"}, 64'(qb.size()), 64'd0);
    endtask

    task automatic check_reset_a(input string p);
        check({p, "_in_ready"}, 64'(a_ready), 64'd1);
        check({p, "_mem_we"}, 64'(a_we), 64'd0);
        check({p, "_mem_addr"}, 64'(a_addr), 64'd0);
        check({p, "_mem_wdata"}, a_wdata, 64'd0);
        check({p, "_busy"}, 64'(a_busy), 64'd0);
        check({p, "_frame_done"}, 64'(a_done), 64'd0);
    endtask

    localparam logic [127:0] REQ_VEC = {4{16'h0180, 16'h7FFF, 16'h8000, 16'hFFFF}};

    initial begin
        logic acc;
        logic stop;
        int   found;
        a_valid = 1'b0; a_data = '0; a_relu = 1'b0; a_stall = 1'b0;
        b_valid = 1'b0; b_data = '0; b_relu = 1'b0; b_stall = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("after_reset");
        check("b_reset_ready", 64'(b_ready), 64'd1);
        check("b_reset_busy", 64'(b_busy), 64'd0);

        // Requant corners plus two-cycle write latency on the first beat.
        step();
        send_a(REQ_VEC, 1'b0);
        a_valid = 1'b0;
        @(negedge clk);
        check("lat_we_s1", 64'(a_we), 64'd0);
        @(negedge clk);
        check("lat_we", 64'(a_we), 64'd1);
        check("lat_addr", 64'(a_addr), 64'd0);
        check("lat_busy", 64'(a_busy), 64'd1);
        check("rq_norelu", a_wdata, 64'h027F_8000_027F_8000);
        step();
        send_a(REQ_VEC, 1'b1);
        a_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (a_we) found = 1;
        end
        check("rq_relu_seen", 64'(found), 64'd1);
        check("rq_relu", a_wdata, 64'h027F_0000_027F_0000);
        drain("rq");

        // Row wrap at full throughput.
        do_reset();
        for (int k = 0; k < 81; k++) send_a(rand_word(), 1'($urandom_range(0, 1)));
        a_valid = 1'b0;
        drain("row");
        check("row_writes", 64'(a_writes), 64'd81);
        check("row_nogap", 64'(a_last_cyc - a_first_cyc + 1), 64'd81);

        // Backpressure: ten stalled cycles while streaming.
        a_valid = 1'b1;
        a_data = rand_word();
        a_relu = 1'($urandom_range(0, 1));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc = a_ready;
            if (a_stall) check("stall_we", 64'(a_we), 64'd0);
            if (c == 14) begin
                check("bp_ready", 64'(a_ready), 64'd0);
                check("bp_buffered", 64'(qa.size()), 64'd4);
            end
            step();
            if (acc) begin
                a_data = rand_word();
                a_relu = 1'($urandom_range(0, 1));
            end
            if (c == 4) a_stall = 1'b1;
            if (c == 14) a_stall = 1'b0;
        end
        a_valid = 1'b0;
        drain("bp");

        // Reset mid-frame after five writes.
        do_reset();
        a_valid = 1'b1;
        a_data = rand_word();
        stop = 1'b0;
        for (int n = 0; n < 50 && !stop; n++) begin
            @(negedge clk);
            acc = a_ready;
            step();
            if (acc) a_data = rand_word();
            stop = (a_writes >= 5);
        end
        check("mid_writes", 64'(a_writes), 64'd5);
        check("mid_busy", 64'(a_busy), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_a("mid_rst");
        a_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        send_a(rand_word(), 1'b0);
        a_valid = 1'b0;
        drain("mid_restart");
        check("mid_restart_writes", 64'(a_writes), 64'd1);

        // Frame end on the 2x3 instance.
        for (int k = 0; k < 6; k++) send_b(rand_word(), 1'($urandom_range(0, 1)));
        b_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            @(negedge clk);
            if (b_we && b_addr == 26'd5) found = 1;
        end
        check("fe_last_write", 64'(found), 64'd1);
        @(negedge clk);
        check("fe_done", 64'(b_done), 64'd1);
        check("fe_ready_low", 64'(b_ready), 64'd0);
        check("fe_busy_done", 64'(b_busy), 64'd1);
        @(negedge clk);
        check("fe_done_clear", 64'(b_done), 64'd0);
        check("fe_busy_idle", 64'(b_busy), 64'd0);
        check("fe_ready_idle", 64'(b_ready), 64'd1);
        step();
        send_b(rand_word(), 1'b1);
        b_valid = 1'b0;
        drain("fe_next");
        check("fe_done_pulses", 64'(b_done_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fmap_writeback.md
# fmap_writeback

Write-side companion to the CBS convolution row engines: accepts the eight 16-bit per-column-group convolution sums produced each beat, requantizes them to signed 8-bit activations (round, optional ReLU, saturate), packs them into 64-bit words and writes them row-major into the output feature-map RAM. It owns the output-address generation (column/row counters, frame wrap), buffers results in a small FIFO against memory stalls, and back-pressures the convolution pipeline with ready/valid.

## Interface
Parameters:
- LANES, 8, results per beat
- DATA_W, 16, input result width (signed two's complement)
- OUT_W, 8, output activation width (signed)
- SHIFT, 8, requantization right-shift (1..15)
- COLS, 80, words per feature-map row
- ROWS, 640, rows per frame
- FIFO_DEPTH, 4, packed-word buffer entries (power of two)
- ADDR_W, 26, word address width

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  result beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  LANES*DATA_W  {res1..res8}, res1 in [127:112]
- relu_en  in  1  clamp negatives to 0 (sampled with each beat)
- mem_stall  in  1  RAM cannot take a write this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address = row*COLS + col
- mem_wdata  out  LANES*OUT_W  packed bytes, lane1 in [63:56]
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse after last word of frame written

## Operation
- Beat accepted on edge where in_valid && in_ready.
- Per lane: sign-extend to DATA_W+1, add 2^(SHIFT-1), arithmetic shift right SHIFT; if relu_en and negative -> 0; saturate to [-128,127]. No intermediate overflow permitted (17-bit add).
- Quantized lanes registered in stage S1 (s1_valid); next edge pushes S1 into FIFO.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH and state != DONE. Overflow impossible by construction.
- mem_we = fifo non-empty && !mem_stall && state == RUN; mem_wdata = FIFO head; mem_addr = row*COLS + col (registered counters). On each write edge: pop FIFO, col++; col==COLS-1 -> col=0, row++.
- FSM: IDLE -> RUN on first accepted beat; RUN -> DONE on edge committing write with row==ROWS-1, col==COLS-1; DONE (one cycle: frame_done=1, counters cleared) -> IDLE. Beats may be accepted in IDLE.
- mem_stall high: mem_we low; FIFO, counters hold; S1 may still push if FIFO has room.
- Simultaneous push and pop: FIFO count unchanged, both happen.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0; FIFO empty, S1 invalid, row=col=0, state IDLE.
- Latency: beat accepted at edge E0 -> in S1 after E0 -> in FIFO after E1 -> mem_we high in cycle after E1, write committed at E2 (no stall).
- Sustained throughput one word/cycle with in_valid held and mem_stall low.
- mem_we is combinational from registered state and mem_stall; all other outputs registered or derived from registered state.
- Reset mid-frame: immediate return to reset values; buffered data discarded.
- frame_done asserted exactly one cycle, the cycle after the final write edge; in_ready low that cycle.

## Structure
- Shared package cnn_pkg: LANES, DATA_W, OUT_W, wb_state_t enum {IDLE, RUN, DONE}, requant function (round/relu/saturate) for reuse by future layers.
- One sub-module: wb_fifo (synchronous FIFO, width LANES*OUT_W, depth FIFO_DEPTH, count output, same clk/rst).

## Test plan
- Requant: lanes 0x0180, 0x7FFF, 0x8000, 0xFFFF, relu_en=0 -> mem_wdata bytes 0x02, 0x7F, 0x80, 0x00; same with relu_en=1 -> 0x02, 0x7F, 0x00, 0x00.
- Latency: single beat after reset -> mem_we high 2 cycles after acceptance edge, mem_addr=0, busy=1.
- Row wrap: 81 beats back-to-back -> addresses 0..80 contiguous, beat 81 written at row 1 col 0 (addr 80), no gaps.
- Backpressure: mem_stall high 10 cycles while streaming -> in_ready drops after 4 buffered words (FIFO+S1), no loss/duplication, order preserved after release.
- Frame end: ROWS=2, COLS=3 overrides, 6 beats -> last write addr 5, frame_done pulse next cycle, busy=0 after, next beat writes addr 0.
- Reset mid-frame: assert rst after 5 writes with FIFO non-empty -> all outputs at reset values same cycle; next frame starts at addr 0.
